vga_timing: RTL and testbench
=============================

VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 SHALL have parameters, each name/default/meaning: H_VIS 640 visible pixels; H_FP 16 h front porch; H_SYNC 96 h sync width; H_BP 48 h back porch; V_VIS 480 visible lines; V_FP 10 v front porch; V_SYNC 2 v sync width; V_BP 33 v back porch.
REQ-002 SHALL have port clk50MHz, input, 1 bit: the one clock, 50 MHz, all state on its rising edge.
REQ-003 SHALL have port clr, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port hSync, output, 1 bit: horizontal sync, active-low.
REQ-005 SHALL have port vSync, output, 1 bit: vertical sync, active-low.
REQ-006 SHALL have port bright, output, 1 bit: high only inside the visible 640x480 region.
REQ-007 SHALL have port hCount, output, 10 bits: current pixel column, 0..H_TOTAL-1.
REQ-008 SHALL have port vCount, output, 10 bits: current line, 0..V_TOTAL-1.

Function
REQ-009 SHALL define H_TOTAL = H_VIS+H_FP+H_SYNC+H_BP (800 by default) and V_TOTAL = V_VIS+V_FP+V_SYNC+V_BP (525 by default).
REQ-010 SHALL keep an internal 1-bit pixel-tick register that toggles on every clk50MHz edge, for a 25 MHz pixel rate.
REQ-011 SHALL advance the counters only on edges where the tick register is 1 before the toggle, so each hCount value lasts exactly 2 clk50MHz cycles.
REQ-012 SHALL increment hCount on each advance; at H_TOTAL-1 it wraps to 0 and vCount increments.
REQ-013 SHALL wrap vCount from V_TOTAL-1 to 0 when hCount wraps on line V_TOTAL-1, giving a frame of 420000 pixel ticks (840000 clk cycles) by default.
REQ-014 SHALL count hCount/vCount from the start of the visible region: visible 0..H_VIS-1, then front porch, sync, back porch; vertical follows the same order.
REQ-015 SHALL drive hSync low exactly for H_VIS+H_FP <= hCount < H_VIS+H_FP+H_SYNC (656..751 default), high otherwise.
REQ-016 SHALL drive vSync low exactly for V_VIS+V_FP <= vCount < V_VIS+V_FP+V_SYNC (490..491 default), high otherwise.
REQ-017 SHALL drive bright = (hCount < H_VIS) AND (vCount < V_VIS).
REQ-018 SHALL decode hSync, vSync and bright combinationally from the counter registers, so all outputs change in the same cycle as the counters, with zero latency.
REQ-019 SHALL never let the counters reach H_TOTAL or V_TOTAL, and SHALL keep them free-running with no stall input.

Reset
REQ-020 SHALL, while clr=0, asynchronously force hCount=0, vCount=0 and tick=0.
REQ-021 SHALL, while clr=0, force hSync=1, vSync=1 and bright=0, overriding the decode.
REQ-022 SHALL, after clr rises, hold hCount=0 for the first 2 clock edges; hCount=1 SHALL appear after the 2nd edge.
REQ-023 SHALL, when clr is asserted mid-line or mid-frame, return immediately to the REQ-020/021 state, with no partial frame completion.

Structure
REQ-024 SHALL place the default timing constants (visible, porch and sync widths, H_TOTAL, V_TOTAL) in a shared package vga_pkg, reused by the bit generator and the top level.
REQ-025 SHALL implement the horizontal/vertical counter pair as one sub-module, vga_counter, instantiated once; the sync/bright decode stays in vga_timing.

Verification
REQ-026 SHALL cover reset: hold clr=0 for 10 cycles, then release -> hCount=0, vCount=0, hSync=1, vSync=1, bright=0 during reset; bright=1 immediately after release; hCount=1 after the 2nd edge.
REQ-027 SHALL cover line timing: run 1 line -> hCount 639->640 drops bright; hSync falls at hCount=656, rises at 752; hCount wraps 799->0 with vCount 0->1; line period 1600 clk cycles.
REQ-028 SHALL cover frame timing: run 1 frame -> vSync low only for vCount 490..491 (3200 clk cycles); vCount wraps 524->0 at cycle 840000; bright=0 for vCount 480..524.
REQ-029 SHALL cover mid-frame reset: assert clr=0 at vCount=300, hCount=400 -> counters 0 without waiting for a clock edge; after release, timing resumes from 0 per REQ-022.
REQ-030 SHALL cover the full-frame invariant: over 2 frames, bright=1 for exactly 640x480x2 clk cycles per frame, and hSync/vSync are never low while bright=1.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing constants and counter type.
// Defaults describe 640x480 @ 60 Hz with a 25 MHz pixel rate.
package vga_pkg;

    localparam int CNT_W = 10;

    localparam int H_VIS_D  = 640;
    localparam int H_FP_D   = 16;
    localparam int H_SYNC_D = 96;
    localparam int H_BP_D   = 48;
    localparam int V_VIS_D  = 480;
    localparam int V_FP_D   = 10;
    localparam int V_SYNC_D = 2;
    localparam int V_BP_D   = 33;

    localparam int H_TOTAL_D = H_VIS_D + H_FP_D + H_SYNC_D + H_BP_D;
    localparam int V_TOTAL_D = V_VIS_D + V_FP_D + V_SYNC_D + V_BP_D;

    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/vga_counter.sv
// Free-running pixel/line counter pair advancing once every
// two clock cycles, gated by a toggling pixel tick.
module vga_counter
    import vga_pkg::*;
#(
    parameter int H_TOTAL = H_TOTAL_D,
    parameter int V_TOTAL = V_TOTAL_D
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [CNT_W-1:0] h_count,
    output logic [CNT_W-1:0] v_count
);

    localparam cnt_t H_MAX = cnt_t'(H_TOTAL - 1);
    localparam cnt_t V_MAX = cnt_t'(V_TOTAL - 1);

    logic tick_q, tick_d;
    cnt_t h_q, h_d;
    cnt_t v_q, v_d;

    always_comb begin
        tick_d = ~tick_q;
        h_d    = h_q;
        v_d    = v_q;
        // Advance only on the edge where the tick is already high.
        if (tick_q) begin
            if (h_q == H_MAX) begin
                h_d = '0;
                if (v_q == V_MAX) begin
                    v_d = '0;
                end else begin
                    v_d = v_q + cnt_t'(1);
                end
            end else begin
                h_d = h_q + cnt_t'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q <= 1'b0;
            h_q    <= '0;
            v_q    <= '0;
        end else begin
            tick_q <= tick_d;
            h_q    <= h_d;
            v_q    <= v_d;
        end
    end

    assign h_count = h_q;
    assign v_count = v_q;

endmodule

// File: rtl/vga_timing.sv
// VGA sync generator: counter pair plus zero-latency
// decode of hSync, vSync and bright.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_VIS  = H_VIS_D,
    parameter int H_FP   = H_FP_D,
    parameter int H_SYNC = H_SYNC_D,
    parameter int H_BP   = H_BP_D,
    parameter int V_VIS  = V_VIS_D,
    parameter int V_FP   = V_FP_D,
    parameter int V_SYNC = V_SYNC_D,
    parameter int V_BP   = V_BP_D
) (
    input  logic             clk50MHz,
    input  logic             clr,
    output logic             hSync,
    output logic             vSync,
    output logic             bright,
    output logic [CNT_W-1:0] hCount,
    output logic [CNT_W-1:0] vCount
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam cnt_t H_VIS_C = cnt_t'(H_VIS);
    localparam cnt_t HS_BEG  = cnt_t'(H_VIS + H_FP);
    localparam cnt_t HS_END  = cnt_t'(H_VIS + H_FP + H_SYNC);
    localparam cnt_t V_VIS_C = cnt_t'(V_VIS);
    localparam cnt_t VS_BEG  = cnt_t'(V_VIS + V_FP);
    localparam cnt_t VS_END  = cnt_t'(V_VIS + V_FP + V_SYNC);

    cnt_t h_cnt;
    cnt_t v_cnt;

    vga_counter #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL)
    ) u_counter (
        .clk     (clk50MHz),
        .rst_n   (clr),
        .h_count (h_cnt),
        .v_count (v_cnt)
    );

    // Reset overrides the decode directly, not just via the counters.
    always_comb begin
        hSync  = 1'b1;
        vSync  = 1'b1;
        bright = 1'b0;
        if (clr) begin
            hSync  = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
            vSync  = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
            bright = (h_cnt < H_VIS_C) && (v_cnt < V_VIS_C);
        end
    end

    assign hCount = h_cnt;
    assign vCount = v_cnt;

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench: default-size instance for reset/line timing,
// shrunken instance for frame-level and mid-frame reset checks.
module tb_vga_timing;

    logic clk = 1'b0;
    logic clr;
    always #10 clk = ~clk;

    logic       d_hs, d_vs, d_br;
    logic [9:0] d_h, d_v;
    logic       s_hs, s_vs, s_br;
    logic [9:0] s_h, s_v;

    int checks = 0;
    int errors = 0;

    vga_timing u_dflt (
        .clk50MHz (clk),
        .clr      (clr),
        .hSync    (d_hs),
        .vSync    (d_vs),
        .bright   (d_br),
        .hCount   (d_h),
        .vCount   (d_v)
    );

    // Small frame: H_TOTAL=25, V_TOTAL=15, 750 clk cycles per frame.
    vga_timing #(
        .H_VIS (16), .H_FP (2), .H_SYNC (4), .H_BP (3),
        .V_VIS (8),  .V_FP (2), .V_SYNC (2), .V_BP (3)
    ) u_small (
        .clk50MHz (clk),
        .clr      (clr),
        .hSync    (s_hs),
        .vSync    (s_vs),
        .bright   (s_br),
        .hCount   (s_h),
        .vCount   (s_v)
    );

    task automatic test_reset;
        clr = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (d_h !== 10'd0 || d_v !== 10'd0) begin
            errors++;
            $display("FAIL rst_counts: h=%0d v=%0d want 0 0", d_h, d_v);
        end
        checks++;
        if (d_hs !== 1'b1 || d_vs !== 1'b1 || d_br !== 1'b0) begin
            errors++;
            $display("FAIL rst_outs: hs=%b vs=%b br=%b want 1 1 0",
                     d_hs, d_vs, d_br);
        end
        clr = 1'b1;
        #1;
        checks++;
        if (d_br !== 1'b1 || d_h !== 10'd0) begin
            errors++;
            $display("FAIL rel_bright: br=%b h=%0d want 1 0", d_br, d_h);
        end
        @(negedge clk);
        checks++;
        if (d_h !== 10'd0) begin
            errors++;
            $display("FAIL rel_edge1: h=%0d want 0", d_h);
        end
        @(negedge clk);
        checks++;
        if (d_h !== 10'd1) begin
            errors++;
            $display("FAIL rel_edge2: h=%0d want 1", d_h);
        end
    endtask

    task automatic test_line;
        int cyc = 0;
        int c1 = -1;
        int c2 = -1;
        int br_prev_h = -1;
        int br_fall_h = -1;
        int hs_fall_h = -1;
        int hs_rise_h = -1;
        int wrap_prev_h = -1;
        int wrap_h = -1;
        logic [9:0] ph, pv;
        logic pbr, phs;
        ph = d_h; pv = d_v; pbr = d_br; phs = d_hs;
        while (cyc < 4000 && c2 < 0) begin
            @(negedge clk);
            cyc++;
            if (pbr && !d_br && br_fall_h < 0) begin
                br_prev_h = int'(ph);
                br_fall_h = int'(d_h);
            end
            if (phs && !d_hs && hs_fall_h < 0) hs_fall_h = int'(d_h);
            if (!phs && d_hs && hs_rise_h < 0) hs_rise_h = int'(d_h);
            if (pv == 10'd0 && d_v == 10'd1) begin
                c1 = cyc;
                wrap_prev_h = int'(ph);
                wrap_h = int'(d_h);
            end
            if (pv == 10'd1 && d_v == 10'd2) c2 = cyc;
            ph = d_h; pv = d_v; pbr = d_br; phs = d_hs;
        end
        checks++;
        if (br_prev_h != 639 || br_fall_h != 640) begin
            errors++;
            $display("FAIL bright_edge: h %0d->%0d want 639->640",
                     br_prev_h, br_fall_h);
        end
        checks++;
        if (hs_fall_h != 656) begin
            errors++;
            $display("FAIL hsync_fall: h=%0d want 656", hs_fall_h);
        end
        checks++;
        if (hs_rise_h != 752) begin
            errors++;
            $display("FAIL hsync_rise: h=%0d want 752", hs_rise_h);
        end
        checks++;
        if (wrap_prev_h != 799 || wrap_h != 0) begin
            errors++;
            $display("FAIL h_wrap: h %0d->%0d want 799->0",
                     wrap_prev_h, wrap_h);
        end
        checks++;
        if (c1 < 0 || c2 < 0 || (c2 - c1) != 1600) begin
            errors++;
            $display("FAIL line_period: c1=%0d c2=%0d want diff 1600",
                     c1, c2);
        end
    endtask

    task automatic test_frame;
        int br_cnt[2];
        int vs_cnt[2];
        int bad_vs = 0;
        int bad_inv = 0;
        int bad_br = 0;
        int bad_rng = 0;
        int wrap_e = -1;
        int f;
        logic [9:0] pv;
        br_cnt = '{0, 0};
        vs_cnt = '{0, 0};
        clr = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        #1;
        pv = s_v;
        for (int e = 0; e < 1500; e++) begin
            if (e > 0) @(negedge clk);
            f = e / 750;
            if (s_br) br_cnt[f]++;
            if (!s_vs) vs_cnt[f]++;
            if (!s_vs && (s_v < 10'd10 || s_v > 10'd11)) bad_vs++;
            if (s_br && (!s_hs || !s_vs)) bad_inv++;
            if (s_br && s_v >= 10'd8) bad_br++;
            if (s_h >= 10'd25 || s_v >= 10'd15) bad_rng++;
            if (e > 0 && pv == 10'd14 && s_v == 10'd0 && wrap_e < 0)
                wrap_e = e;
            pv = s_v;
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (br_cnt[i] != 256) begin
                errors++;
                $display("FAIL bright_count f%0d: %0d want 256",
                         i, br_cnt[i]);
            end
            checks++;
            if (vs_cnt[i] != 100) begin
                errors++;
                $display("FAIL vsync_count f%0d: %0d want 100",
                         i, vs_cnt[i]);
            end
        end
        checks++;
        if (wrap_e != 750) begin
            errors++;
            $display("FAIL v_wrap: cycle %0d want 750", wrap_e);
        end
        checks++;
        if (bad_vs != 0) begin
            errors++;
            $display("FAIL vsync_window: %0d bad samples want 0", bad_vs);
        end
        checks++;
        if (bad_inv != 0) begin
            errors++;
            $display("FAIL sync_in_bright: %0d samples want 0", bad_inv);
        end
        checks++;
        if (bad_br != 0) begin
            errors++;
            $display("FAIL bright_vblank: %0d samples want 0", bad_br);
        end
        checks++;
        if (bad_rng != 0) begin
            errors++;
            $display("FAIL cnt_range: %0d samples want 0", bad_rng);
        end
    endtask

    task automatic test_mid_reset;
        int n = 0;
        while (n < 1000 && !(s_v == 10'd5 && s_h == 10'd10)) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 1000) begin
            errors++;
            $display("FAIL mid_reach: timeout h=%0d v=%0d want 10 5",
                     s_h, s_v);
        end
        clr = 1'b0;
        #1;
        checks++;
        if (s_h !== 10'd0 || s_v !== 10'd0 ||
            d_h !== 10'd0 || d_v !== 10'd0) begin
            errors++;
            $display("FAIL mid_async: s=%0d/%0d d=%0d/%0d want zeros",
                     s_h, s_v, d_h, d_v);
        end
        checks++;
        if (s_hs !== 1'b1 || s_vs !== 1'b1 || s_br !== 1'b0) begin
            errors++;
            $display("FAIL mid_outs: hs=%b vs=%b br=%b want 1 1 0",
                     s_hs, s_vs, s_br);
        end
        repeat (3) @(negedge clk);
        clr = 1'b1;
        #1;
        checks++;
        if (s_h !== 10'd0 || s_br !== 1'b1) begin
            errors++;
            $display("FAIL mid_rel: h=%0d br=%b want 0 1", s_h, s_br);
        end
        @(negedge clk);
        checks++;
        if (s_h !== 10'd0) begin
            errors++;
            $display("FAIL mid_edge1: h=%0d want 0", s_h);
        end
        @(negedge clk);
        checks++;
        if (s_h !== 10'd1) begin
            errors++;
            $display("FAIL mid_edge2: h=%0d want 1", s_h);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (s_h !== 10'd2 || s_v !== 10'd0) begin
            errors++;
            $display("FAIL mid_edge4: h=%0d v=%0d want 2 0", s_h, s_v);
        end
    endtask

    initial begin
        clr = 1'b0;
        @(negedge clk);
        test_reset();
        test_line();
        test_frame();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
